// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: stereo PCM to I2S serialiser with a one-entry holding buffer.
// Optional build macro: I2S_LEFT_JUSTIFIED_EN selects left-justified framing
// (no one-BCK data delay); undefined gives standard I2S.
module i2s_audio_tx #(
    parameter int SAMPLE_W     = 16,
    parameter int BCK_HALF_DIV = 9
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                i2s_bck,
    output logic                i2s_lrck,
    output logic                i2s_data,
    output logic                frame_start,
    output logic                underrun
);

    localparam int DIV_W = (BCK_HALF_DIV > 1) ? $clog2(BCK_HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCK_HALF_DIV - 1);

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;

    logic [DIV_W-1:0]    r_div_cnt;
    logic                r_bck;
    logic [5:0]          r_bit_cnt;
    logic                r_lrck;
    logic                r_data;
    logic [63:0]         r_shift;
    logic [63:0]         r_frame_prev;
    logic                r_frame_start;
    logic                r_underrun;

    logic [SAMPLE_W-1:0] r_buf_l;
    logic [SAMPLE_W-1:0] r_buf_r;
    logic                r_full;
    logic                r_ready;

`ifndef I2S_LEFT_JUSTIFIED_EN
    logic                r_delay;
`endif

    logic                w_div_tc;
    logic                w_fall;
    logic                w_load;
    logic [5:0]          w_bit_next;
    logic [31:0]         w_slot_l;
    logic [31:0]         w_slot_r;
    logic [63:0]         w_frame_new;
    logic [63:0]         w_shift_src;
    logic                w_accept;
    logic                w_full_next;

    // Reset assertion is immediate; release is held off two clk edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_div_tc   = (r_div_cnt == DIV_TC);
    assign w_fall     = w_div_tc && r_bck;
    assign w_load     = w_fall && (r_bit_cnt == 6'd63);
    assign w_bit_next = r_bit_cnt + 6'd1;

    // Samples sit MSB-aligned in their 32-bit slot with zero padding below.
    assign w_slot_l    = 32'(r_buf_l) << (32 - SAMPLE_W);
    assign w_slot_r    = 32'(r_buf_r) << (32 - SAMPLE_W);
    assign w_frame_new = r_full ? {w_slot_l, w_slot_r} : r_frame_prev;
    assign w_shift_src = w_load ? w_frame_new : r_shift;

    // A collision with a frame load still sees the buffer empty; the new pair
    // waits for the following frame.
    assign w_accept    = sample_valid && r_ready;
    assign w_full_next = w_accept ? 1'b1 : (w_load ? 1'b0 : r_full);

    // BCK half-period divider.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_div_cnt <= '0;
            r_bck     <= 1'b0;
        end else if (w_div_tc) begin
            r_div_cnt <= '0;
            r_bck     <= ~r_bck;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Bit position, word select and serial data all advance on BCK falls.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bit_cnt    <= 6'd63;
            r_lrck       <= 1'b0;
            r_data       <= 1'b0;
            r_shift      <= '0;
            r_frame_prev <= '0;
`ifndef I2S_LEFT_JUSTIFIED_EN
            r_delay      <= 1'b0;
`endif
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_next;
            r_lrck    <= w_bit_next[5];
            r_shift   <= {w_shift_src[62:0], 1'b0};
`ifdef I2S_LEFT_JUSTIFIED_EN
            r_data    <= w_shift_src[63];
`else
            r_data    <= r_delay;
            r_delay   <= w_shift_src[63];
`endif
            if (w_load) r_frame_prev <= w_frame_new;
        end
    end

    // Frame-level status pulses, aligned with the shifter load.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= w_load;
            r_underrun    <= w_load && !r_full;
        end
    end

    // One-entry holding buffer; ready mirrors emptiness of the buffer.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_buf_l <= '0;
            r_buf_r <= '0;
            r_full  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_full  <= w_full_next;
            r_ready <= !w_full_next;
            if (w_accept) begin
                r_buf_l <= sample_l;
                r_buf_r <= sample_r;
            end
        end
    end

    assign sample_ready = r_ready;
    assign i2s_bck      = r_bck;
    assign i2s_lrck     = r_lrck;
    assign i2s_data     = r_data;
    assign frame_start  = r_frame_start;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Testbench for i2s_audio_tx (BCK_HALF_DIV=2, SAMPLE_W=16).
// Honours I2S_LEFT_JUSTIFIED_EN when the design is built with it.
module tb_i2s_audio_tx;

    localparam int SW  = 16;
    localparam int DIV = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [SW-1:0] sample_l = '0;
    logic [SW-1:0] sample_r = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          i2s_bck, i2s_lrck, i2s_data, frame_start, underrun;

    i2s_audio_tx #(.SAMPLE_W(SW), .BCK_HALF_DIV(DIV)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_bck      (i2s_bck),
        .i2s_lrck     (i2s_lrck),
        .i2s_data     (i2s_data),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_frame(input logic [15:0] l, input logic [15:0] r);
        return {l, 16'h0000, r, 16'h0000};
    endfunction

    // Word seen on the wire for frame f, given the last bit of the previous frame.
    function automatic logic [63:0] wexp(input logic [63:0] f, input logic pb);
`ifdef I2S_LEFT_JUSTIFIED_EN
        return f;
`else
        return {pb, f[63:1]};
`endif
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [63:0] acc_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] m_last_frame = '0;
    logic        m_acc_pend = 1'b0;
    logic [63:0] m_acc_word = '0;
    logic [63:0] wire_w = '0, lr_w = '0, last_wire = '0;
    logic [63:0] f_sel;
    logic        exp_ur;
    bit          armed = 0;
    bit          bp_mode = 0;
    int          bit_idx = 0;
    int          acc_since_load = 0;
    logic        prev_bck = 1'b0, prev_lrck = 1'b0;
    longint      cyc = 0, last_rise = -1, last_lrck_rise = -1;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            acc_q.delete();
            exp_q.delete();
            m_last_frame   = '0;
            m_acc_pend     = 1'b0;
            armed          = 0;
            bit_idx        = 0;
            acc_since_load = 0;
            last_rise      = -1;
            last_lrck_rise = -1;
            prev_bck       = 1'b0;
            prev_lrck      = 1'b0;
        end else begin
            if (frame_start) begin
                if (bp_mode) chk("bp_one_accept", 64'(acc_since_load <= 1), 64'd1);
                acc_since_load = 0;
                exp_ur = (acc_q.size() == 0);
                chk("underrun", 64'(underrun), 64'(exp_ur));
                f_sel = exp_ur ? m_last_frame : acc_q.pop_front();
                exp_q.push_back(wexp(f_sel, m_last_frame[0]));
                m_last_frame = f_sel;
                armed   = 1;
                bit_idx = 0;
            end
            if (m_acc_pend) begin
                acc_q.push_back(m_acc_word);
                acc_since_load++;
            end
            m_acc_pend = sample_valid && sample_ready;
            m_acc_word = mk_frame(sample_l, sample_r);
            if (underrun) chk("ur_with_fs", 64'(frame_start), 64'd1);
            if (i2s_bck && !prev_bck) begin
                if (last_rise >= 0) chk("bck_period", 64'(cyc - last_rise), 64'(2 * DIV));
                last_rise = cyc;
                if (armed) begin
                    wire_w = {wire_w[62:0], i2s_data};
                    lr_w   = {lr_w[62:0], i2s_lrck};
                    bit_idx++;
                    if (bit_idx == 64) begin
                        chk("lrck_pattern", lr_w, {32'h0, 32'hFFFF_FFFF});
                        if (exp_q.size() == 0) chk("wire_unexpected", 64'd1, 64'd0);
                        else chk("wire_frame", wire_w, exp_q.pop_front());
                        last_wire = wire_w;
                        bit_idx   = 0;
                    end
                end
            end
            if (i2s_lrck && !prev_lrck) begin
                if (last_lrck_rise >= 0)
                    chk("lrck_period", 64'(cyc - last_lrck_rise), 64'(128 * DIV));
                last_lrck_rise = cyc;
            end
            prev_bck  = i2s_bck;
            prev_lrck = i2s_lrck;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_fs();
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (frame_start) return;
        end
        chk("timeout_frame_start", 64'd0, 64'd1);
    endtask

    task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (sample_ready) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        chk("timeout_accept", 64'd0, 64'd1);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        chk("rst_bck",   64'(i2s_bck),      64'd0);
        chk("rst_lrck",  64'(i2s_lrck),     64'd0);
        chk("rst_data",  64'(i2s_data),     64'd0);
        chk("rst_ready", 64'(sample_ready), 64'd1);
        chk("rst_fs",    64'(frame_start),  64'd0);
        chk("rst_ur",    64'(underrun),     64'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Basic frame
        send_pair(16'hA5C3, 16'h0F01);
        sample_valid = 1'b0;
        wait_fs();
        wait_fs();
`ifdef I2S_LEFT_JUSTIFIED_EN
        chk("basic_wire", last_wire, 64'hA5C3_0000_0F01_0000);
`else
        chk("basic_wire", last_wire, 64'h52E1_8000_0780_8000);
`endif

        // Backpressure: valid held high with 1,2,3
        bp_mode = 1;
        send_pair(16'h0001, 16'h0001);
        chk("bp_ready_low", 64'(sample_ready), 64'd0);
        send_pair(16'h0002, 16'h0002);
        send_pair(16'h0003, 16'h0003);
        sample_valid = 1'b0;
        wait_fs();
        wait_fs();
        bp_mode = 0;
        chk("bp_last", last_wire, wexp(mk_frame(16'h0003, 16'h0003), 1'b0));

        // Underrun: one pair then stall
        send_pair(16'h8000, 16'h7FFF);
        sample_valid = 1'b0;
        wait_fs();
        for (int k = 0; k < 3; k++) begin
            wait_fs();
            chk("ur_repeat", 64'(underrun), 64'd1);
        end
        chk("ur_wire", last_wire, wexp(mk_frame(16'h8000, 16'h7FFF), 1'b0));

        // Collision: accept on the load edge
        wait_fs();
        repeat (255) @(posedge clk);
        #1;
        sample_l = 16'h1234;
        sample_r = 16'h5678;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        chk("coll_fs", 64'(frame_start), 64'd1);
        chk("coll_ur", 64'(underrun), 64'd1);
        wait_fs();
        chk("coll_next_ur", 64'(underrun), 64'd0);
        wait_fs();
        chk("coll_wire", last_wire, wexp(mk_frame(16'h1234, 16'h5678), 1'b0));

        // Reset mid-frame at bit_cnt=40 with a pair buffered
        wait_fs();
        sample_l = 16'hDEAD;
        sample_r = 16'hBEEF;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        chk("mid_buf_full", 64'(sample_ready), 64'd0);
        repeat (159) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_bck",   64'(i2s_bck),      64'd0);
        chk("mid_lrck",  64'(i2s_lrck),     64'd0);
        chk("mid_data",  64'(i2s_data),     64'd0);
        chk("mid_ready", 64'(sample_ready), 64'd1);
        chk("mid_fs",    64'(frame_start),  64'd0);
        chk("mid_ur",    64'(underrun),     64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_fs();
        chk("post_rst_ur",    64'(underrun),     64'd1);
        chk("post_rst_ready", 64'(sample_ready), 64'd1);
        wait_fs();
        chk("post_rst_zero", last_wire, 64'd0);
        chk("post_rst_ur2",  64'(underrun), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
- Serialises stereo PCM from the Genesis core audio mixer (YM2612 + PSG sum) onto the board I2S pins `I2S_BCK`, `I2S_LRCK` and `I2S_DATA`.
- Sits directly downstream of the core audio output and is instantiated only in builds that expose I2S.
- A one-entry holding buffer and a valid/ready handshake decouple the mixer sample rate from the I2S frame rate.
- On underrun, the last accepted frame is repeated.

Parameters:
- SAMPLE_W, 16: bits per channel sample, legal range 1..32. Data is sent MSB first; unused slot bits are zero.
- BCK_HALF_DIV, 9: `clk` cycles per BCK half-period, minimum 1. BCK = clk/(2*BCK_HALF_DIV). Frame rate fs = clk/(128*BCK_HALF_DIV).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_l  in  SAMPLE_W  left sample, two's complement.
- sample_r  in  SAMPLE_W  right sample, two's complement.
- sample_valid  in  1  the source presents a stereo pair.
- sample_ready  out  1  the holding buffer is empty; the pair is accepted when valid && ready.
- i2s_bck  out  1  bit clock.
- i2s_lrck  out  1  word select: 0 = left slot, 1 = right slot.
- i2s_data  out  1  serial data; changes only on BCK falling edges.
- frame_start  out  1  one-clk pulse when a new frame is loaded into the shifter.
- underrun  out  1  one-clk pulse when a frame starts with the holding buffer empty.

Behaviour:
- Reset state: bck=0, lrck=0, data=0, sample_ready=1, frame_start=0, underrun=0. The holding buffer, the 64-bit frame shifter and the delay bit clear to 0. bit_cnt=63 and div_cnt=0.
- Divider:
  - div_cnt counts 0..BCK_HALF_DIV-1.
  - At the terminal count it returns to 0 and bck toggles.
  - A toggle 1→0 is a "fall" event; a toggle 0→1 is a "rise" event. No other logic acts on rise.
- On each fall event, bit_cnt increments modulo 64, and lrck <= new bit_cnt[5] in the same cycle.
- Frame format: frame word = {L, zero pad to 32, R, zero pad to 32}, MSB first.
- Frame load, when bit_cnt wraps 63→0:
  - If the holding buffer is full, the shifter loads the frame word from it and the buffer empties.
  - If the holding buffer is empty, the shifter reloads the previous frame word and underrun pulses.
  - frame_start pulses in both cases.
- Data path on every fall event:
  - i2s_data <= delay bit.
  - delay bit <= shifter MSB.
  - The shifter shifts left by 1. On a load cycle, shifter MSB means the freshly loaded word's MSB.
  - Result: standard I2S with a one-BCK delay after each LRCK edge. Slot bit p carries frame bit p-1.
  - Slot 0 of each frame carries the last bit of the previous frame: pad zero, or R LSB when SAMPLE_W=32.
- Handshake:
  - sample_ready = buffer empty; it is registered and updates the cycle after a state change.
  - Accept captures sample_l and sample_r into the buffer.
  - Accept and frame load in the same cycle with the buffer empty: the load sees the empty buffer (underrun, previous frame repeated) and the new pair is held for the next frame.
  - Buffer full at frame load with sample_valid high in the same cycle: the buffer empties but the new pair is not accepted that cycle, because ready was low.
  - sample_valid may drop at any time. No pair is lost once accepted.
- Latency: an accepted pair's L MSB appears on i2s_data at the second fall event after the next frame load.
- Sample-rate mismatch:
  - Source too fast: held by backpressure.
  - Source too slow: repeated frames, each flagged by underrun.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). A pending buffered pair is discarded. On release, the first fall event starts a fresh frame with underrun asserted.
- Reset deassertion is synchronised internally with a 2-flop release synchroniser; assertion stays asynchronous.

Optional Feature:
- I2S_LEFT_JUSTIFIED_EN:
  - When defined, the delay bit is bypassed: i2s_data <= shifter MSB at each fall event, so slot bit p carries frame bit p (left-justified format).
  - When undefined, standard I2S with the one-bit delay.
  - Handshake, LRCK and the counters are identical in both builds.

Test Plan:
- Basic frame:
  - Stimulus: BCK_HALF_DIV=2, SAMPLE_W=16, one pair L=16'hA5C3, R=16'h0F01.
  - Response: the LRCK-low slot reads 0,1010010111000011,0x15 and the LRCK-high slot reads 0,0000111100000001,0x15.
  - Response: the BCK period is 4 clk and the LRCK period is 256 clk.
- Backpressure:
  - Stimulus: hold sample_valid high with incrementing L=R values from 16'h0001.
  - Response: exactly one accept per 64 fall events; sample_ready is low between loads; sequence 1,2,3 appears on the wire with none skipped.
- Underrun:
  - Stimulus: deliver one pair (L=16'h8000, R=16'h7FFF), then stall.
  - Response: subsequent frames repeat 8000/7FFF; underrun pulses once per frame, coincident with frame_start.
- Collision:
  - Stimulus: the accept lands on the same clk as the frame load with the buffer empty.
  - Response: underrun=1 for that frame; the new pair is transmitted in the following frame.
- Reset mid-frame:
  - Stimulus: assert reset_n=0 at bit_cnt=40 with a pair buffered.
  - Response: outputs go to reset values within the same clk; after release the first frame repeats zero data, underrun=1 and sample_ready=1.
- Left-justified build:
  - Stimulus: build with I2S_LEFT_JUSTIFIED_EN defined and rerun the basic-frame scenario.
  - Response: slot bit 0 equals the L MSB (1) and the stream is shifted one BCK earlier.
